// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the serializer_d6 slice.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry word holding register; a write in the same cycle as a read keeps it full.
module ser_hold_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  logic [WIDTH-1:0] data_r;
  logic             full_r;

  // Capture on write; a read alone empties the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= {WIDTH{1'b0}};
      full_r <= 1'b0;
    end else if (write) begin
      data_r <= data;
      full_r <= 1'b1;
    end else if (read) begin
      data_r <= data_r;
      full_r <= 1'b0;
    end else begin
      data_r <= data_r;
      full_r <= full_r;
    end
  end

  assign q    = data_r;
  assign full = full_r;

endmodule

// File: rtl/serializer_d6_chk.sv
// Invariant checker for the serializer control state; has no functional outputs.
import serializer_pkg::*;

module serializer_d6_chk (
  input logic       clk,
  input logic       rst,
  input ser_state_t state,
  input logic       last,
  input logic       hold_full,
  input logic       in_ready,
  input logic       o_valid
);

  a_hold_never_idle: assert property (@(posedge clk) disable iff (rst)
    hold_full |-> (state == SHIFT));

  a_no_ready_when_blocked: assert property (@(posedge clk) disable iff (rst)
    (hold_full && !last) |-> !in_ready);

  a_valid_tracks_state: assert property (@(posedge clk) disable iff (rst)
    o_valid == (state == SHIFT));

endmodule

// File: rtl/serializer_d6.sv
// Parallel-in/serial-out stage: ready/valid word input, one-word hold buffer, gapless bit stream out.
import serializer_pkg::*;

module serializer_d6 #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             o,
  output logic             o_valid,
  output logic             o_last
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state_r, state_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] sr_r, sr_nxt_s, sr_shift_s;
  logic [WIDTH-1:0] hold_q_s;
  logic             hold_full_s;
  logic             hold_wr_s, hold_rd_s;
  logic             last_s, load_now_s, accept_s;

  assign last_s     = (state_r == SHIFT) && (cnt_r == CNT_LAST);
  assign load_now_s = (state_r == IDLE) || last_s;
  // The last-bit cycle frees the hold entry, so a new word can be taken even when it is full.
  assign in_ready   = !rst && (!hold_full_s || last_s);
  assign accept_s   = in_valid && in_ready;

  // Shift one position toward the transmit end.
  always_comb begin
    sr_shift_s = sr_r;
    if (MSB_FIRST) begin
      sr_shift_s = {sr_r[WIDTH-2:0], 1'b0};
    end else begin
      sr_shift_s = {1'b0, sr_r[WIDTH-1:1]};
    end
  end

  // Next-state, counter, shift register and hold-buffer control.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    sr_nxt_s    = sr_r;
    hold_wr_s   = 1'b0;
    hold_rd_s   = 1'b0;
    if (load_now_s) begin
      if (hold_full_s) begin
        sr_nxt_s    = hold_q_s;
        hold_rd_s   = 1'b1;
        hold_wr_s   = accept_s;
        cnt_nxt_s   = {CW{1'b0}};
        state_nxt_s = SHIFT;
      end else if (accept_s) begin
        sr_nxt_s    = in_data;
        cnt_nxt_s   = {CW{1'b0}};
        state_nxt_s = SHIFT;
      end else begin
        state_nxt_s = IDLE;
      end
    end else begin
      case (state_r)
        SHIFT: begin
          sr_nxt_s  = sr_shift_s;
          cnt_nxt_s = cnt_r + CW'(1);
          hold_wr_s = accept_s;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      sr_r    <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      sr_r    <= sr_nxt_s;
    end
  end

  ser_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .write(hold_wr_s),
    .read (hold_rd_s),
    .data (in_data),
    .q    (hold_q_s),
    .full (hold_full_s)
  );

  assign o       = (state_r == SHIFT) ? (MSB_FIRST ? sr_r[WIDTH-1] : sr_r[0]) : 1'b0;
  assign o_valid = (state_r == SHIFT);
  assign o_last  = last_s;

  serializer_d6_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .state    (state_r),
    .last     (last_s),
    .hold_full(hold_full_s),
    .in_ready (in_ready),
    .o_valid  (o_valid)
  );

endmodule

// File: tb/tb_serializer_d6.sv
// Directed, table-driven bench for serializer_d6 (MSB-first and LSB-first instances).
module tb_serializer_d6;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       o;
    logic       ov;
    logic       ol;
    logic       rdy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data, in_data_l;
  logic       in_valid, in_valid_l;
  logic       in_ready, o, o_valid, o_last;
  logic       in_ready_l, o_l, o_valid_l, o_last_l;
  int         checks = 0;
  int         errors = 0;
  vec_t       tbl[$];

  always #5 clk = ~clk;

  serializer_d6 #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .o(o), .o_valid(o_valid), .o_last(o_last)
  );

  serializer_d6 #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_data(in_data_l), .in_valid(in_valid_l), .in_ready(in_ready_l),
    .o(o_l), .o_valid(o_valid_l), .o_last(o_last_l)
  );

  function automatic vec_t mk(input logic v, input logic [3:0] d, input logic eo,
                              input logic eov, input logic eol, input logic erdy);
    vec_t r;
    r.v = v; r.d = d; r.o = eo; r.ov = eov; r.ol = eol; r.rdy = erdy;
    return r;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " o"}, o, 1'b0);
    chk({tag, " o_valid"}, o_valid, 1'b0);
    chk({tag, " o_last"}, o_last, 1'b0);
    chk({tag, " in_ready"}, in_ready, 1'b0);
    chk({tag, " lsb o"}, o_l, 1'b0);
    chk({tag, " lsb o_valid"}, o_valid_l, 1'b0);
    chk({tag, " lsb o_last"}, o_last_l, 1'b0);
    chk({tag, " lsb in_ready"}, in_ready_l, 1'b0);
  endtask

  // Check outputs on the falling edge, then drive inputs for the next rising edge.
  task automatic step(input bit sel, input logic v, input logic [3:0] d, input logic eo,
                      input logic eov, input logic eol, input logic erdy, input string tag);
    @(negedge clk);
    if (!sel) begin
      chk({tag, " o"}, o, eo);
      chk({tag, " o_valid"}, o_valid, eov);
      chk({tag, " o_last"}, o_last, eol);
      chk({tag, " in_ready"}, in_ready, erdy);
      in_valid = v; in_data = d; in_valid_l = 1'b0;
    end else begin
      chk({tag, " o"}, o_l, eo);
      chk({tag, " o_valid"}, o_valid_l, eov);
      chk({tag, " o_last"}, o_last_l, eol);
      chk({tag, " in_ready"}, in_ready_l, erdy);
      in_valid_l = v; in_data_l = d; in_valid = 1'b0;
    end
  endtask

  initial begin
    // single word 1011
    tbl.push_back(mk(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1));
    // back-to-back 1100, 0101; junk data offered while not ready
    tbl.push_back(mk(1'b1, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b0101, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1));
    // three words 1001, 0110, 1110; third accepted on first word's last bit
    tbl.push_back(mk(1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1));

    rst = 1'b1;
    in_valid = 1'b0; in_data = 4'b0000;
    in_valid_l = 1'b0; in_data_l = 4'b0000;
    #2;
    chk_zero("reset");
    #10;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b0, tbl[i].v, tbl[i].d, tbl[i].o, tbl[i].ov, tbl[i].ol, tbl[i].rdy,
           $sformatf("tbl[%0d]", i));
    end

    // asynchronous reset in the middle of a word
    step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, "mid_rst acc");
    step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, "mid_rst bit0");
    #2 rst = 1'b1;
    #1 chk_zero("mid_rst async");
    @(posedge clk);
    #1 chk_zero("mid_rst held");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, "mid_rst release");

    // reset with a held word: the held 0011 must never appear
    step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, "hold_rst acc1");
    step(1'b0, 1'b1, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b1, "hold_rst acc2");
    step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, "hold_rst bit1");
    #2 rst = 1'b1;
    #1 chk_zero("hold_rst async");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, "hold_rst new");
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, "hold_rst b0");
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, "hold_rst b1");
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, "hold_rst b2");
    step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, "hold_rst b3");
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("hold_rst idle%0d", k));
    end

    // LSB-first instance
    step(1'b1, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, "lsb acc");
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, "lsb b0");
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, "lsb b1");
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, "lsb b2");
    step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, "lsb b3");
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, "lsb idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
